// File: rtl/op_seq_pkg.sv
// op_seq_pkg: shared definitions for the operand-fetch / execute / write-back
// sequencer. Holds the 3-bit state encoding and the operation codes.
package op_seq_pkg;

  // Explicit 3-bit codes, so the encoding stays fixed whatever the tool does.
  typedef enum logic [2:0] {
    S_IDLE = 3'd0,
    S_RD_A = 3'd1,
    S_LD_A = 3'd2,
    S_RD_B = 3'd3,
    S_LD_B = 3'd4,
    S_EXEC = 3'd5,
    S_WB   = 3'd6,
    S_DONE = 3'd7
  } state_e;

  localparam logic OP_ADD = 1'b0;
  localparam logic OP_SUB = 1'b1;

endpackage

// File: rtl/addsub_core.sv
// addsub_core: combinational WIDTH-bit adder/subtractor with flags.
//   a, b  : operands
//   sub   : 0 = a+b, 1 = a-b (computed as a + ~b + 1)
//   sum   : low WIDTH bits of the result (wraps)
//   cout  : carry-out for ADD, no-borrow (a >= b unsigned) for SUB
//   ovf   : signed two's-complement overflow
module addsub_core #(
  parameter int WIDTH = 64
) (
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             sub,
  output logic [WIDTH-1:0] sum,
  output logic             cout,
  output logic             ovf
);

  logic [WIDTH-1:0] b_eff;
  logic [WIDTH:0]   sum_ext;

  always_comb begin
    b_eff   = sub ? ~b : b;
    // The subtract's +1 rides in as the carry-in, so one adder serves both ops.
    sum_ext = {1'b0, a} + {1'b0, b_eff} + {{WIDTH{1'b0}}, sub};
    sum     = sum_ext[WIDTH-1:0];
    cout    = sum_ext[WIDTH];
    // Overflow: both addends share a sign and the result's sign differs.
    ovf     = (a[WIDTH-1] == b_eff[WIDTH-1]) && (sum_ext[WIDTH-1] != a[WIDTH-1]);
  end

endmodule

// File: rtl/op_sequencer.sv
// op_sequencer: start/busy/done sequencer that fetches two operands from a
// 1-cycle-latency data memory, performs ADD or SUB, and optionally writes the
// result back.
//   clk, rst                  : clock, asynchronous active-high reset
//   start, op, wb_en          : request, operation (0 ADD / 1 SUB), write-back enable
//   addr_a, addr_b, addr_dst  : operand and destination addresses
//   busy, done                : busy from accept to IDLE; one-cycle done pulse
//   result, carry, ovf        : registered result and flags of the last EXEC
//   mem_addr, mem_re, mem_we  : memory address and strobes
//   mem_wdata, mem_rdata      : write data (= result) and read data (1-cycle latency)
module op_sequencer
  import op_seq_pkg::*;
#(
  parameter int WIDTH  = 64,
  parameter int ADDR_W = 5
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic              op,
  input  logic              wb_en,
  input  logic [ADDR_W-1:0] addr_a,
  input  logic [ADDR_W-1:0] addr_b,
  input  logic [ADDR_W-1:0] addr_dst,
  output logic              busy,
  output logic              done,
  output logic [WIDTH-1:0]  result,
  output logic              carry,
  output logic              ovf,
  output logic [ADDR_W-1:0] mem_addr,
  output logic              mem_re,
  output logic              mem_we,
  output logic [WIDTH-1:0]  mem_wdata,
  input  logic [WIDTH-1:0]  mem_rdata
);

  state_e state_q, state_d;

  logic              op_q, wb_en_q;
  logic [ADDR_W-1:0] addr_a_q, addr_b_q, addr_dst_q;
  logic [WIDTH-1:0]  opa_q, opb_q, result_q;
  logic              carry_q, ovf_q;

  logic [WIDTH-1:0]  core_sum;
  logic              core_cout, core_ovf;

  addsub_core #(.WIDTH(WIDTH)) u_core (
    .a    (opa_q),
    .b    (opb_q),
    .sub  (op_q == OP_SUB),
    .sum  (core_sum),
    .cout (core_cout),
    .ovf  (core_ovf)
  );

  // Next-state and Moore outputs, all decoded from the registered state.
  always_comb begin
    // NOTE: every output gets a default first so no path through the case
    // leaves a signal unassigned, which would infer a latch.
    state_d  = state_q;
    busy     = (state_q != S_IDLE);
    done     = 1'b0;
    mem_addr = '0;
    mem_re   = 1'b0;
    mem_we   = 1'b0;
    unique case (state_q)
      S_IDLE: if (start) state_d = S_RD_A;
      S_RD_A: begin
        mem_addr = addr_a_q;
        mem_re   = 1'b1;
        state_d  = S_LD_A;
      end
      S_LD_A: state_d = S_RD_B;
      S_RD_B: begin
        mem_addr = addr_b_q;
        mem_re   = 1'b1;
        state_d  = S_LD_B;
      end
      S_LD_B: state_d = S_EXEC;
      S_EXEC: state_d = wb_en_q ? S_WB : S_DONE;
      S_WB: begin
        mem_addr = addr_dst_q;
        mem_we   = 1'b1;
        state_d  = S_DONE;
      end
      S_DONE: begin
        done    = 1'b1;
        state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values regardless of statement order.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      // NOTE: operand and latched-field registers are reset too, so an abort
      // leaves no stale operands or destination visible after release.
      state_q    <= S_IDLE;
      op_q       <= 1'b0;
      wb_en_q    <= 1'b0;
      addr_a_q   <= '0;
      addr_b_q   <= '0;
      addr_dst_q <= '0;
      opa_q      <= '0;
      opb_q      <= '0;
      result_q   <= '0;
      carry_q    <= 1'b0;
      ovf_q      <= 1'b0;
    end else begin
      state_q <= state_d;
      // Request fields are captured only on accept; later input changes are ignored.
      if (state_q == S_IDLE && start) begin
        op_q       <= op;
        wb_en_q    <= wb_en;
        addr_a_q   <= addr_a;
        addr_b_q   <= addr_b;
        addr_dst_q <= addr_dst;
      end
      if (state_q == S_LD_A) opa_q <= mem_rdata;
      if (state_q == S_LD_B) opb_q <= mem_rdata;
      if (state_q == S_EXEC) begin
        result_q <= core_sum;
        carry_q  <= core_cout;
        ovf_q    <= core_ovf;
      end
    end
  end

  assign result    = result_q;
  assign carry     = carry_q;
  assign ovf       = ovf_q;
  assign mem_wdata = result_q;

endmodule
